// File: rtl/param_cam.sv
// Parametrised CAM: write/invalidate by address, search by content, highest index wins.
// Optional multi-hit flag output enabled by defining CAM_MULTI_HIT_EN.
module param_cam #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic              ren,
  input  logic              inv,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] dout,
  output logic              hit,
  output logic [ADDR_W:0]   count,
  output logic              full
`ifdef CAM_MULTI_HIT_EN
  ,
  output logic              multi_hit
`endif
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;

  logic              in_range;
  logic              do_wr;
  logic              do_inv;
  logic              cur_valid;
  logic [ADDR_W-1:0] match_idx;
  logic              match_any;
`ifdef CAM_MULTI_HIT_EN
  logic              match_multi;
`endif

  assign in_range  = {1'b0, addr} < DEPTH_L;
  assign do_inv    = !ren && inv && in_range;
  assign do_wr     = !ren && !inv && wen && in_range;
  assign cur_valid = in_range ? valid[addr] : 1'b0;
  assign full      = (count == DEPTH_L);

  // Priority match: scanning upward so the highest valid matching index sticks.
  always_comb begin
    match_idx = '0;
    match_any = 1'b0;
`ifdef CAM_MULTI_HIT_EN
    match_multi = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem[i] == din)) begin
`ifdef CAM_MULTI_HIT_EN
        match_multi = match_multi | match_any;
`endif
        match_any = 1'b1;
        match_idx = ADDR_W'(i);
      end
    end
  end

  // Stored words carry no reset; only the valid bits define contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem[addr] <= din;
  end

  // Valid bits and occupancy track writes into empty slots and invalidates of live ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      count <= '0;
    end else if (do_wr) begin
      valid[addr] <= 1'b1;
      if (!cur_valid) count <= count + 1'b1;
    end else if (do_inv) begin
      valid[addr] <= 1'b0;
      if (cur_valid) count <= count - 1'b1;
    end
  end

  // Search result registers, updated only by searches and held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      hit  <= 1'b0;
`ifdef CAM_MULTI_HIT_EN
      multi_hit <= 1'b0;
`endif
    end else if (ren) begin
      dout <= match_idx;
      hit  <= match_any;
`ifdef CAM_MULTI_HIT_EN
      multi_hit <= match_multi;
`endif
    end
  end

endmodule

// File: tb/tb_param_cam.sv
// Self-checking bench for param_cam: vector table plus scoreboard of search results.
// Also exercises out-of-range addressing on a non-power-of-two instance.
module tb_param_cam;

  typedef struct {
    logic       hit;
    logic [3:0] dout;
    logic       multi;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [7:0] d;
    logic       e_hit;
    logic [3:0] e_dout;
    logic [4:0] e_cnt;
    logic       e_multi;
  } vec_t;

  localparam logic [1:0] OP_W = 2'd1;
  localparam logic [1:0] OP_I = 2'd2;
  localparam logic [1:0] OP_S = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       wen, ren, inv;
  logic [7:0] din;
  logic [3:0] addr;
  logic [3:0] dout;
  logic       hit;
  logic [4:0] count;
  logic       full;
`ifdef CAM_MULTI_HIT_EN
  logic       multi_hit;
  logic       multi_hit2;
`endif

  logic       wen2;
  logic       ren2;
  logic       inv2;
  logic [3:0] addr2;
  logic [3:0] dout2;
  logic       hit2;
  logic [4:0] count2;
  logic       full2;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  vec_t vecs[$];

  param_cam #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren), .inv(inv),
    .din(din), .addr(addr), .dout(dout), .hit(hit),
    .count(count), .full(full)
`ifdef CAM_MULTI_HIT_EN
    , .multi_hit(multi_hit)
`endif
  );

  param_cam #(.DATA_W(8), .DEPTH(10)) dut2 (
    .clk(clk), .rst(rst), .wen(wen2), .ren(ren2), .inv(inv2),
    .din(din), .addr(addr2), .dout(dout2), .hit(hit2),
    .count(count2), .full(full2)
`ifdef CAM_MULTI_HIT_EN
    , .multi_hit(multi_hit2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] op, input logic [3:0] a,
                     input logic [7:0] d, input logic h,
                     input logic [3:0] o, input logic [4:0] c,
                     input logic m);
    vec_t v;
    v.op = op; v.a = a; v.d = d;
    v.e_hit = h; v.e_dout = o; v.e_cnt = c; v.e_multi = m;
    vecs.push_back(v);
  endtask

  task automatic step(input string tag, input logic w, input logic r,
                      input logic i, input logic [3:0] a,
                      input logic [7:0] d, input exp_t e);
    exp_t x;
    wen = w; ren = r; inv = i; addr = a; din = d;
    if (r) sbq.push_back(e);
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; inv = 1'b0;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk({tag, " hit"}, 32'(hit), 32'(x.hit));
      chk({tag, " dout"}, 32'(dout), 32'(x.dout));
`ifdef CAM_MULTI_HIT_EN
      chk({tag, " multi"}, 32'(multi_hit), 32'(x.multi));
`endif
    end
  endtask

  function automatic exp_t mk(input logic h, input logic [3:0] o,
                              input logic m);
    exp_t e;
    e.hit = h; e.dout = o; e.multi = m;
    return e;
  endfunction

  initial begin
    rst = 1'b1;
    wen = 0; ren = 0; inv = 0; din = '0; addr = '0;
    wen2 = 0; ren2 = 0; inv2 = 0; addr2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst dout", 32'(dout), 0);
    chk("rst hit", 32'(hit), 0);
    chk("rst count", 32'(count), 0);
    chk("rst full", 32'(full), 0);
    @(negedge clk);
    rst = 1'b0;

    // Out-of-range addresses on DEPTH=10 instance
    wen2 = 1; addr2 = 4'd12; din = 8'h21;
    @(posedge clk); #1;
    chk("oor wr12 count", 32'(count2), 0);
    addr2 = 4'd9;
    @(posedge clk); #1;
    chk("wr9 count", 32'(count2), 1);
    addr2 = 4'd15;
    @(posedge clk); #1;
    chk("oor wr15 count", 32'(count2), 1);
    wen2 = 0; inv2 = 1; addr2 = 4'd13;
    @(posedge clk); #1;
    chk("oor inv13 count", 32'(count2), 1);
    inv2 = 0; din = '0;

    // Table-driven main sequence
    add(OP_S, 0, 8'h00, 0, 0, 0, 0);
    add(OP_W, 4'hC, 8'd10, 0, 0, 1, 0);
    add(OP_W, 4'hE, 8'd30, 0, 0, 2, 0);
    add(OP_W, 4'h0, 8'd30, 0, 0, 3, 0);
    add(OP_W, 4'h2, 8'd30, 0, 0, 4, 0);
    add(OP_S, 0, 8'd30, 1, 4'hE, 4, 1);
    add(OP_S, 0, 8'd10, 1, 4'hC, 4, 0);
    add(OP_S, 0, 8'd40, 0, 0, 4, 0);
    add(OP_W, 4'hE, 8'd50, 0, 0, 4, 0);
    add(OP_S, 0, 8'd30, 1, 4'h2, 4, 1);
    add(OP_S, 0, 8'd50, 1, 4'hE, 4, 0);
    add(OP_I, 4'hC, 8'd0, 0, 0, 3, 0);
    add(OP_S, 0, 8'd10, 0, 0, 3, 0);
    add(OP_I, 4'hC, 8'd0, 0, 0, 3, 0);
    for (int k = 0; k < vecs.size(); k++) begin
      string t;
      t = $sformatf("v%0d", k);
      step(t, vecs[k].op == OP_W, vecs[k].op == OP_S,
           vecs[k].op == OP_I, vecs[k].a, vecs[k].d,
           mk(vecs[k].e_hit, vecs[k].e_dout, vecs[k].e_multi));
      chk({t, " count"}, 32'(count), 32'(vecs[k].e_cnt));
    end

    // Fill every entry with its own index
    for (int k = 0; k < 16; k++) begin
      step("fill", 1, 0, 0, 4'(k), 8'(k), mk(0, 0, 0));
      if (k == 14) chk("fill14 full", 32'(full), 0);
    end
    chk("fill count", 32'(count), 16);
    chk("fill full", 32'(full), 1);
    step("s15", 0, 1, 0, 0, 8'd15, mk(1, 4'hF, 0));
    step("s30", 0, 1, 0, 0, 8'd30, mk(0, 0, 0));
    step("ovw full", 1, 0, 0, 4'd7, 8'd7, mk(0, 0, 0));
    chk("ovw full count", 32'(count), 16);

    // ren beats wen
    step("rw", 1, 1, 0, 4'd3, 8'd99, mk(0, 0, 0));
    chk("rw count", 32'(count), 16);
    step("s3", 0, 1, 0, 0, 8'd3, mk(1, 4'd3, 0));
    step("s99", 0, 1, 0, 0, 8'd99, mk(0, 0, 0));
    // inv beats wen
    step("iw", 1, 0, 1, 4'd5, 8'd77, mk(0, 0, 0));
    chk("iw count", 32'(count), 15);
    chk("iw full", 32'(full), 0);
    step("s77", 0, 1, 0, 0, 8'd77, mk(0, 0, 0));
    step("s5", 0, 1, 0, 0, 8'd5, mk(0, 0, 0));
    step("w5", 1, 0, 0, 4'd5, 8'd5, mk(0, 0, 0));
    chk("w5 count", 32'(count), 16);
    step("s3b", 0, 1, 0, 0, 8'd3, mk(1, 4'd3, 0));

    // Reset between a search request and its result edge
    @(negedge clk);
    ren = 1; din = 8'd15;
    #2 rst = 1'b1;
    #1;
    chk("arst dout", 32'(dout), 0);
    chk("arst hit", 32'(hit), 0);
    chk("arst count", 32'(count), 0);
    chk("arst full", 32'(full), 0);
    @(posedge clk); #1;
    ren = 0;
    chk("arst edge hit", 32'(hit), 0);
    chk("arst edge dout", 32'(dout), 0);
    @(negedge clk);
    rst = 1'b0;
    step("post s3", 0, 1, 0, 0, 8'd3, mk(0, 0, 0));
    chk("post count", 32'(count), 0);
    step("post w3", 1, 0, 0, 4'd9, 8'd3, mk(0, 0, 0));
    step("post s3b", 0, 1, 0, 0, 8'd3, mk(1, 4'd9, 0));
    chk("post count1", 32'(count), 1);
    chk("sb drained", 32'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
